bus_arb: RTL and testbench

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_arb_if.sv | 33 +++
 rtl/bus_ser.sv | 108 ++++++++++
 rtl/bus_arb.sv | 110 +++++++++++
 tb/tb_bus_arb.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared frame state encoding and phase lengths for bus_arb.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BIT   = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int START_CYC = 1;
    localparam int BIT_CYC   = 2;
    localparam int STOP_CYC  = 3;
    localparam int IDLE_GAP  = 1;

endpackage
`default_nettype wire

// File: rtl/bus_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_if
// Description : Requester/arbiter bundle: requests, payloads, grants and the
//               serial scl/sda pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [OW-1:0]      owner;
    logic               busy;
    logic               scl;
    logic               sda;

    modport master (
        output req, data,
        input  gnt, ack, owner, busy, scl, sda
    );

    modport slave (
        input  req, data,
        output gnt, ack, owner, busy, scl, sda
    );
endinterface
`default_nettype wire

// File: rtl/bus_ser.sv
`default_nettype none
// ============================================================================
// Module      : bus_ser
// Description : Serialises one latched DW-bit word as START, MSB-first bits
//               and STOP on scl/sda; done strobes one cycle before the last
//               STOP cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_ser
    import bus_pkg::*;
#(
    parameter int DW = 4
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          load,
    input  wire [DW-1:0] word,
    output logic         scl,
    output logic         sda,
    output logic         done
);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic [BW-1:0] r_bitcnt;
    logic [DW-1:0] r_word;
    logic          r_scl;
    logic          r_sda;
    logic          r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_word   <= '0;
            r_scl    <= 1'b1;
            r_sda    <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_scl <= 1'b1;
                    r_sda <= 1'b1;
                    if (load) begin
                        r_state <= START;
                        r_word  <= word;
                        r_cnt   <= '0;
                        r_sda   <= 1'b0;
                    end
                end
                START: begin
                    if (r_cnt == 2'(START_CYC - 1)) begin
                        r_state  <= BIT;
                        r_cnt    <= '0;
                        r_bitcnt <= '0;
                        r_scl    <= 1'b0;
                        r_sda    <= r_word[DW-1];
                        r_word   <= r_word << 1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BIT: begin
                    if (r_cnt == 2'(BIT_CYC - 1)) begin
                        // sda moves together with the scl fall, never while scl is high
                        r_cnt <= '0;
                        r_scl <= 1'b0;
                        if (r_bitcnt == BW'(DW - 1)) begin
                            r_state <= STOP;
                            r_sda   <= 1'b0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_sda    <= r_word[DW-1];
                            r_word   <= r_word << 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_scl <= 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == 2'(STOP_CYC - 1)) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_bitcnt <= '0;
                        r_scl    <= 1'b1;
                        r_sda    <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_scl  <= 1'b1;
                        r_sda  <= (r_cnt == 2'(STOP_CYC - 2));
                        r_done <= (r_cnt == 2'(STOP_CYC - 3));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign scl  = r_scl;
    assign sda  = r_sda;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb
// Description : Arbitrates NREQ requesters onto one serial scl/sda bus; the
//               winner's word is latched and sent by bus_ser. Round-robin by
//               default, fixed lowest-index priority with BUS_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb
    import bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 4
) (
    input wire       sclk,
    input wire       rst,
    bus_arb_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic [OW-1:0]   r_owner;
    logic            r_busy;
    logic [1:0]      r_gap;
    logic [OW-1:0]   w_win;
    logic [DW-1:0]   w_word;
    logic            w_start;
    logic            w_done;
    logic            w_scl;
    logic            w_sda;

`ifdef BUS_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) w_win = OW'(i);
        end
    end
`else
    logic [OW-1:0] r_last;
    logic [OW-1:0] w_rr_idx;

    // Walk from farthest to nearest after r_last so the nearest active requester wins
    always_comb begin
        w_win    = '0;
        w_rr_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_rr_idx = OW'((int'(r_last) + i) % NREQ);
            if (bus.req[w_rr_idx]) w_win = w_rr_idx;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_last <= OW'(NREQ - 1);
        end else if (w_start) begin
            r_last <= w_win;
        end
    end
`endif

    // The first IDLE cycle after STOP is inherent; r_gap counts any extra ones
    assign w_start = !r_busy && (r_gap == 2'd0) && (|bus.req);
    assign w_word  = bus.data[w_win*DW +: DW];

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_gnt   <= '0;
            r_ack   <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_gap   <= '0;
        end else begin
            r_ack <= w_done ? r_gnt : '0;
            if (|r_ack) begin
                r_gnt  <= '0;
                r_busy <= 1'b0;
                r_gap  <= 2'(IDLE_GAP - 1);
            end else if (w_start) begin
                r_gnt   <= NREQ'(1) << w_win;
                r_busy  <= 1'b1;
                r_owner <= w_win;
            end else if (!r_busy && (r_gap != 2'd0)) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    bus_ser #(
        .DW (DW)
    ) u_ser (
        .clk  (sclk),
        .rst  (rst),
        .load (w_start),
        .word (w_word),
        .scl  (w_scl),
        .sda  (w_sda),
        .done (w_done)
    );

    assign bus.gnt   = r_gnt;
    assign bus.ack   = r_ack;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;
    assign bus.scl   = w_scl;
    assign bus.sda   = w_sda;

endmodule
`default_nettype wire

// File: tb/tb_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arb
// Description : Directed self-checking bench for bus_arb (NREQ=4 and NREQ=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arb;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   n_vec    = 0;
    int   n_miscmp = 0;

    logic p_scl  = 1'b1;
    logic p_sda  = 1'b1;
    logic p_busy = 1'b0;

`ifdef BUS_ARB_FIXED_PRIO_EN
    int order[5] = '{0, 0, 0, 0, 0};
`else
    int order[5] = '{0, 1, 2, 3, 0};
`endif

    bus_arb_if #(.NREQ(4), .DW(4)) bif ();
    bus_arb_if #(.NREQ(1), .DW(4)) bif1 ();

    bus_arb #(.NREQ(4), .DW(4)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bif)
    );

    bus_arb #(.NREQ(1), .DW(4)) dut1 (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bif1)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bif.req  = '0;
        bif.data = '0;
        bif1.req = '0;
        tick();
        tick();
        check("rst_idle", 32'({bif.gnt, bif.ack, bif.busy, bif.scl, bif.sda, bif.owner}),
              32'({4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00}));
        check("rst_idle1", 32'({bif1.gnt, bif1.ack, bif1.busy, bif1.scl, bif1.sda}), 32'b00011);
        rst = 1'b0;
    endtask

    // Called with the T+1 cycle already sampled; follows the frame to T+13
    task automatic watch_frame(input string tag, input logic [3:0] exp_word,
                               input logic [3:0] exp_gnt, input bit drop_at4,
                               input logic [15:0] new_data);
        logic [3:0] word;
        word = '0;
        for (int k = 2; k <= 13; k++) begin
            tick();
            if (k >= 3 && k <= 9 && (k % 2) == 1) word = {word[2:0], bif.sda};
            if (k == 2) check({tag, "_bit_a"}, 32'(bif.scl), 32'd0);
            if (k == 3) check({tag, "_bit_b"}, 32'(bif.scl), 32'd1);
            if (k == 4 && drop_at4) begin
                bif.req  = '0;
                bif.data = new_data;
            end
            if (k == 10) check({tag, "_stop0"}, 32'({bif.scl, bif.sda}), 32'b00);
            if (k == 11) check({tag, "_stop1"}, 32'({bif.scl, bif.sda, bif.ack}), 32'({2'b10, 4'b0000}));
            if (k == 12) check({tag, "_ack"}, 32'({bif.ack, bif.gnt, bif.busy, bif.scl, bif.sda}),
                               32'({exp_gnt, exp_gnt, 3'b111}));
            if (k == 13) check({tag, "_gap"}, 32'({bif.gnt, bif.ack, bif.busy, bif.scl, bif.sda}),
                               32'({4'b0000, 4'b0000, 3'b011}));
        end
        check({tag, "_word"}, 32'(word), 32'(exp_word));
    endtask

    // Bus-level rules that hold on every cycle of every test
    always @(posedge sclk) begin
        #1;
        check("gnt_onehot", 32'($onehot0(bif.gnt)), 32'd1);
        if (p_scl && bif.scl && !(bif.busy && !p_busy) && (bif.ack == 4'b0000))
            check("sda_hold", 32'(bif.sda), 32'(p_sda));
        p_scl  = bif.scl;
        p_sda  = bif.sda;
        p_busy = bif.busy;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] words;
        logic [3:0]  g;

        bif.req   = '0;
        bif.data  = '0;
        bif1.req  = '0;
        bif1.data = '0;

        // Single request, data0=A
        do_reset();
        bif.req  = 4'b0001;
        bif.data = 16'h000A;
        tick();
        check("t1_gnt", 32'({bif.gnt, bif.owner}), 32'({4'b0001, 2'd0}));
        check("t1_start", 32'({bif.busy, bif.scl, bif.sda}), 32'b110);
        bif.req = '0;
        watch_frame("t1", 4'hA, 4'b0001, 1'b0, 16'h0000);

        // All requesters held high
        do_reset();
        words    = 16'h3C59;
        bif.req  = 4'b1111;
        bif.data = words;
        for (int f = 0; f < 5; f++) begin
            tick();
            g = 4'b0001 << order[f];
            check("t2_gnt", 32'(bif.gnt), 32'(g));
            check("t2_owner", 32'(bif.owner), 32'(order[f]));
            if (f == 4) bif.req = '0;
            watch_frame("t2", words[order[f]*4 +: 4], g, 1'b0, 16'h0000);
        end

        // Owner 2, request dropped and payload changed mid-frame
        do_reset();
        bif.req  = 4'b0100;
        bif.data = 16'h0600;
        tick();
        check("t3_gnt", 32'({bif.gnt, bif.owner}), 32'({4'b0100, 2'd2}));
        watch_frame("t3", 4'h6, 4'b0100, 1'b1, 16'h0900);

        // Reset in the middle of a frame
        do_reset();
        bif.req  = 4'b0001;
        bif.data = 16'h000F;
        tick();
        check("t4_gnt", 32'(bif.gnt), 32'b0001);
        bif.req = '0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            check("t4_noack", 32'(bif.ack), 32'd0);
        end
        rst = 1'b1;
        #1;
        check("t4_sync", 32'(bif.gnt), 32'b0001);
        tick();
        check("t4_abort", 32'({bif.gnt, bif.ack, bif.busy, bif.scl, bif.sda, bif.owner}),
              32'({4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00}));
        rst      = 1'b0;
        bif.req  = 4'b0100;
        bif.data = 16'h0300;
        tick();
        check("t4_regnt", 32'({bif.gnt, bif.owner}), 32'({4'b0100, 2'd2}));
        bif.req = '0;
        watch_frame("t4", 4'h3, 4'b0100, 1'b0, 16'h0000);

        // Single requester held: back-to-back frames; NREQ=1 instance alongside
        do_reset();
        bif.req   = 4'b0010;
        bif.data  = 16'h00A0;
        bif1.req  = 1'b1;
        bif1.data = 4'h5;
        tick();
        check("t5_gnt", 32'(bif.gnt), 32'b0010);
        check("t5_gnt1", 32'({bif1.gnt, bif1.owner, bif1.busy}), 32'b101);
        watch_frame("t5a", 4'hA, 4'b0010, 1'b0, 16'h0000);
        tick();
        check("t5_regnt", 32'({bif.gnt, bif.owner}), 32'({4'b0010, 2'd1}));
        check("t5_regnt1", 32'({bif1.gnt, bif1.owner, bif1.busy}), 32'b101);
        bif.req  = '0;
        bif1.req = 1'b0;
        watch_frame("t5b", 4'hA, 4'b0010, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
